// File: rtl/mux_i5_arbiter.sv
// Round-robin arbiter for the shared 32-bit result mux with five inputs.
// It grants one requester at a time and drives the mux select from the
// registered o_sel. With no grant it drives SEL_IDLE, so the mux output floats.
// Optional build macro: MUX_I5_ARB_TURNAROUND_EN. When it is defined, every
// change of owner passes through one idle TURN cycle, so two drivers never
// overlap on the shared bus.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner, outputs idle, search from pointer each cycle
// S_GRANT | o_sel is the owner, hold counter tracks ownership length
// S_TURN  | one idle cycle between two different owners (macro only)
module mux_i5_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter logic [2:0]  SEL_IDLE = 3'b111
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_req,
  output logic [4:0] o_gnt,
  output logic [2:0] o_sel,
  output logic       o_valid
);

  localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit HOLD_LIMITED = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT
`ifdef MUX_I5_ARB_TURNAROUND_EN
    , S_TURN
`endif
  } state_t;

  state_t        state_q, state_n;
  logic [2:0]    ptr_q, ptr_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [4:0]    gnt_n;
  logic [2:0]    sel_n;
  logic          valid_n;

  logic [3:0]    pick_ptr, pick_rel;
  logic [2:0]    rel_ptr;
  logic          release_own;

  // Returns {found, index}: first set bit of req scanning upward from start, wrapping 4->0.
  function automatic logic [3:0] rr_pick(input logic [4:0] req, input logic [2:0] start);
    logic [3:0] k;
    logic [3:0] res;
    res = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      k = {1'b0, start} + 4'(i);
      if (k >= 4'd5) k = k - 4'd5;
      if (!res[3] && req[k[2:0]]) res = {1'b1, k[2:0]};
    end
    return res;
  endfunction

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
      o_gnt   <= 5'b00000;
      o_sel   <= SEL_IDLE;
      o_valid <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      o_gnt   <= gnt_n;
      o_sel   <= sel_n;
      o_valid <= valid_n;
    end
  end

  // Next-state, pointer, counter and output selection.
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    gnt_n   = o_gnt;
    sel_n   = o_sel;
    valid_n = o_valid;

    // While in GRANT, o_sel holds the owner index.
    rel_ptr     = (o_sel >= 3'd4) ? 3'd0 : o_sel + 3'd1;
    pick_ptr    = rr_pick(i_req, ptr_q);
    pick_rel    = rr_pick(i_req, rel_ptr);
    release_own = !i_req[o_sel] || (HOLD_LIMITED && (cnt_q == HOLD_MAX));

    case (state_q)
      S_GRANT: begin
        if (!release_own) begin
          if (HOLD_LIMITED && (cnt_q < HOLD_MAX)) cnt_n = cnt_q + CNT_ONE;
        end else begin
          ptr_n = rel_ptr;
          if (!pick_rel[3]) begin
            state_n = S_IDLE;
            gnt_n   = 5'b00000;
            sel_n   = SEL_IDLE;
            valid_n = 1'b0;
          end else if (pick_rel[2:0] == o_sel) begin
            // Hold expiry with the owner as the only requester: re-grant in place.
            cnt_n = CNT_ONE;
          end else begin
`ifdef MUX_I5_ARB_TURNAROUND_EN
            state_n = S_TURN;
            gnt_n   = 5'b00000;
            sel_n   = SEL_IDLE;
            valid_n = 1'b0;
`else
            gnt_n   = 5'b00001 << pick_rel[2:0];
            sel_n   = pick_rel[2:0];
            valid_n = 1'b1;
            cnt_n   = CNT_ONE;
`endif
          end
        end
      end
      default: begin
        // IDLE and TURN behave alike: search from the pointer.
        if (pick_ptr[3]) begin
          state_n = S_GRANT;
          gnt_n   = 5'b00001 << pick_ptr[2:0];
          sel_n   = pick_ptr[2:0];
          valid_n = 1'b1;
          cnt_n   = CNT_ONE;
        end else begin
          state_n = S_IDLE;
          gnt_n   = 5'b00000;
          sel_n   = SEL_IDLE;
          valid_n = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: doc/mux_i5_arbiter.md
# mux_i5_arbiter

- Round-robin arbiter for one shared 32-bit datapath resource fed through the 5-input result mux.
- Five requesters each present data on one mux input; the arbiter grants one requester at a time and drives the mux `i_control` select from its registered `o_sel`.
- When no requester is granted it drives the out-of-range select `3'b111`, so the mux output floats to Z.
- Ownership is bounded by a hold limit to guarantee fairness.

## Interface
- `MAX_HOLD`, 8: max consecutive grant cycles per ownership; 0 = unlimited; legal 0..255.
- `SEL_IDLE`, 3'b111: select driven when no grant; must be 3'b101..3'b111.
- `i_clk` input 1: rising-edge clock; the only clock.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_req` input 5: request vector; bit n = requester n (mux input n).
- `o_gnt` output 5: registered one-hot grant; all-zero when idle.
- `o_sel` output 3: registered mux select; equals the granted index, else `SEL_IDLE`.
- `o_valid` output 1: registered; high when `o_gnt` is non-zero.

## Operation
- States: IDLE, GRANT, TURN (TURN exists only with the macro below).
- Reset values: state=IDLE, `o_gnt`=5'b00000, `o_sel`=`SEL_IDLE`, `o_valid`=0, RR pointer=0, hold counter=0.
- Selection: search `i_req` starting at pointer p, ascending with wrap 4->0; the first set bit wins.
- IDLE, `i_req`==0: stay. Any bit set: winner w -> GRANT, `o_gnt`=1<<w, `o_sel`=w, counter=1.
- GRANT, owner o. Release occurs when `i_req[o]`==0, or when `MAX_HOLD`!=0 and counter==`MAX_HOLD`.
- GRANT, no release: hold, counter+1. The counter saturates at `MAX_HOLD`; it is width `$clog2(MAX_HOLD+1)`, minimum 1 bit.
- GRANT, release: pointer <- (o+1) mod 5; search the remaining requests from the new pointer.
  - No request pending: -> IDLE, outputs idle.
  - Winner w==o (hold expiry, only o still requesting): stay GRANT; `o_gnt`/`o_sel` unchanged; counter=1.
  - Winner w!=o: hand over, direct or via TURN per Configuration.
- TURN: one cycle, outputs idle. Next edge: search from the pointer; winner -> GRANT counter=1, none -> IDLE.
- Any requester change in `i_req` is visible only at the next edge; there is no combinational req-to-gnt path.
- `o_sel` never holds 3'b101/3'b110 unless `SEL_IDLE` is set to them; `o_gnt` is always one-hot or zero.

## Timing
- Request to grant: 1 cycle. `i_req[n]` rising before edge k gives `o_gnt[n]` high after edge k if n wins.
- Minimum grant length: 1 cycle, even if req drops in the same cycle the grant appears.
- Release latency: `i_req[o]` low before edge k drops or moves the grant after edge k.
- Direct handover: 0 idle cycles between owners.
- TURN handover: exactly 1 idle cycle.
- Worst-case wait with all requesting and `MAX_HOLD`=H: 4*H cycles direct, 4*(H+1) with TURN.
- Simultaneous requests in IDLE: the RR pointer decides. After reset, index 0 wins.
- Reset mid-grant: at the reset edge all outputs and state return to reset values; the pointer returns to 0.

## Configuration
- Macro: `MUX_I5_ARB_TURNAROUND_EN`.
- Defined: a change of owner passes through TURN, with one cycle of `o_sel`=`SEL_IDLE` and `o_gnt`=0 to avoid driver overlap on the shared bus.
- Undefined: TURN is not compiled; the new owner is granted on the same edge the old owner releases.
- Same-owner re-grant on hold expiry never passes through TURN in either build.

## Test plan
- Reset then idle: `i_rst`=1 for 2 cycles, `i_req`=0 -> `o_gnt`=0, `o_sel`=3'b111, `o_valid`=0 on every cycle.
- Single request: `i_req`=5'b00100 held for 3 cycles, then 0 -> `o_sel`=2, `o_gnt`=5'b00100 for 3 cycles starting 1 cycle after the req; idle one cycle after req drops.
- Round-robin with all requesting: `i_req`=5'b11111, `MAX_HOLD`=2, no macro -> `o_sel` sequence 0,0,1,1,2,2,3,3,4,4,0 with no idle cycles.
- Same config with `MUX_I5_ARB_TURNAROUND_EN` -> 0,0,7,1,1,7,2,2,...
- Hold expiry, sole requester: `i_req`=5'b01000, `MAX_HOLD`=3 -> `o_sel`=3 continuously, no gap.
- Pointer wrap and reset mid-grant:
  - Owner 4 releases with `i_req`=5'b00011 -> next `o_sel`=0.
  - Assert `i_rst` while owner 1 is granted -> idle outputs on the next cycle.
  - Then `i_req`=5'b00110 -> `o_sel`=1.
